alloc_ctl: RTL and testbench
============================

# alloc_ctl

Request sequencer on the initiator side of the linked-memory allocator's two-port interface. It accepts one host command at a time over a valid/ready handshake and issues the matching single-cycle alloc, free, read or write strobe. It captures the allocator's next-cycle result and returns it over a valid/ready response channel. It also provides a multi-step FREE_CHAIN command that walks a pointer-linked chain of cells and frees each one, returning the count as a fixnum.

## Interface
- DATA_SZ, 16, bits per word; tag constants are fixed at MUT_TAG=16'h4000 and ZERO=16'h8000.
- ADDR_SZ, 8, allocator address bits.
- MEM_MAX, 1<<ADDR_SZ, maximum chain length before FREE_CHAIN declares a cycle.

Ports:
- i_clk  in  1  single domain clock, all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  host command valid.
- o_cmd_ready  out  1  high only in IDLE and not halted.
- i_cmd  in  3  0 ALLOC, 1 FREE, 2 READ, 3 WRITE, 4 FREE_CHAIN, 5-7 invalid.
- i_cmd_addr  in  DATA_SZ  address for FREE, READ, WRITE and FREE_CHAIN.
- i_cmd_data  in  DATA_SZ  initial data for ALLOC, write data for WRITE.
- o_rsp_valid  out  1  response valid, held until accepted.
- i_rsp_ready  in  1  host accepts response.
- o_rsp_data  out  DATA_SZ  result word.
- o_rsp_err  out  1  response carries an error.
- o_halt  out  1  sticky fault indication.
- o_alloc, o_free, o_wr, o_rd  out  1 each  allocator request strobes.
- o_data, o_free_addr, o_waddr, o_wdata, o_raddr  out  DATA_SZ each  allocator request operands.
- i_alloc_addr, i_rdata  in  DATA_SZ each  allocator results, valid one cycle after the strobe.
- i_err  in  1  allocator error flag.

## Operation
- States: IDLE, REQ, WAIT, RSP, CH_RD, CH_RDW, CH_FR, CH_FRW, HALT.
- A command is accepted on the edge where i_cmd_valid and o_cmd_ready are both high. The controller latches the command, address and data.
- ALLOC, FREE, READ, WRITE: IDLE -> REQ -> WAIT -> RSP.
  - REQ drives exactly one strobe with its operands.
  - WAIT samples the results.
  - rsp_data is i_alloc_addr for ALLOC, i_rdata for READ, and 16'h0000 for FREE and WRITE.
- Invalid code: IDLE -> RSP with rsp_err=1, rsp_data=0, no strobes, no halt.
- FREE_CHAIN with a start address where bit 14 (MUT_TAG) is clear: IDLE -> RSP, rsp_data=16'h8000, no strobes.
- FREE_CHAIN per cell, starting at cur=start:
  - CH_RD: o_rd with o_raddr=cur.
  - CH_RDW: next<=i_rdata.
  - CH_FR: o_free with o_free_addr=cur.
  - CH_FRW: count<=count+1, check i_err.
  - Then, if next[14] is set, cur<=next and go to CH_RD; otherwise go to RSP with rsp_data = 16'h8000 | count.
- Cycle guard: if count reaches MEM_MAX while next[14] is still set, give an error response and go to HALT.
- At most one strobe is high in any cycle. Alloc and free are never combined, so the allocator never sees a conflicting request.
- Error handling:
  - i_err is sampled in WAIT, CH_RDW and CH_FRW.
  - If it is high: rsp_err=1, rsp_data=0, enter RSP.
  - After that response is accepted, go to HALT.
  - HALT: o_halt=1, o_cmd_ready=0, no strobes; left only by reset.
- RSP: o_rsp_valid=1 until i_rsp_ready. Return to IDLE, or to HALT after an error response.
- The count register is ADDR_SZ+1 bits and is zero-extended into the fixnum.

## Timing
- Reset values: all strobes 0, all operand outputs 0, o_rsp_valid=0, o_rsp_data=0, o_rsp_err=0, o_halt=0, state IDLE, o_cmd_ready=1.
- Reset asserted mid-operation drops all strobes immediately, asynchronously. Any in-flight response is discarded.
- All outputs are registered.
- Simple commands: accept edge E0, strobe high E0–E1, result sampled at E2, o_rsp_valid high from E2. Back-to-back throughput is one command per 3 cycles plus response hold.
- FREE_CHAIN costs 4 cycles per cell. Latency from accept to o_rsp_valid is 4·N+1 edges for N cells.
- A response accepted in the same cycle it appears returns the block to IDLE. o_cmd_ready is then high on the next cycle.

## Test plan
- After reset, ALLOC with data 16'h1234: o_alloc high for exactly 1 cycle with o_data=16'h1234. The response arrives 2 cycles after accept with rsp_data=16'h5000 and rsp_err=0.
- WRITE 16'hBEEF to 16'h5000, then READ 16'h5000: single o_wr, then single o_rd. Responses are 16'h0000 and 16'hBEEF, no overlap of strobes.
- Build chain A=ALLOC(16'h0001), B=ALLOC(A), C=ALLOC(B), then FREE_CHAIN C: strobes in order rd C, free C, rd B, free B, rd A, free A. Response 16'h8003 after 13 edges.
- FREE_CHAIN 16'h0001: no strobes, next-cycle response 16'h8000. Invalid code 6: rsp_err=1, o_halt stays 0.
- Force i_err=1 in WAIT of a READ: rsp_err=1, then o_halt=1, o_cmd_ready=0, and strobes stay low for 20 cycles until i_rst_n pulses low.
- Drop i_rst_n in CH_FRW of a 3-cell chain: strobes go to 0 immediately. After release, o_cmd_ready=1 and o_rsp_valid=0.

Source files
------------

// File: rtl/alloc_ctl.sv
// Initiator-side sequencer for the linked-memory allocator: one host command at a time,
// single-cycle allocator strobes, registered response channel, and a FREE_CHAIN walker.
module alloc_ctl #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 8,
  parameter int MEM_MAX = 1 << ADDR_SZ
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [2:0]         i_cmd,
  input  logic [DATA_SZ-1:0] i_cmd_addr,
  input  logic [DATA_SZ-1:0] i_cmd_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_SZ-1:0] o_rsp_data,
  output logic               o_rsp_err,
  output logic               o_halt,
  output logic               o_alloc,
  output logic               o_free,
  output logic               o_wr,
  output logic               o_rd,
  output logic [DATA_SZ-1:0] o_data,
  output logic [DATA_SZ-1:0] o_free_addr,
  output logic [DATA_SZ-1:0] o_waddr,
  output logic [DATA_SZ-1:0] o_wdata,
  output logic [DATA_SZ-1:0] o_raddr,
  input  logic [DATA_SZ-1:0] i_alloc_addr,
  input  logic [DATA_SZ-1:0] i_rdata,
  input  logic               i_err
);

  localparam logic [DATA_SZ-1:0] MUT_TAG = 16'h4000;
  localparam logic [DATA_SZ-1:0] ZERO    = 16'h8000;
  localparam logic [ADDR_SZ:0]   CNT_MAX = (ADDR_SZ+1)'(MEM_MAX);

  localparam logic [2:0] C_ALLOC = 3'd0;
  localparam logic [2:0] C_FREE  = 3'd1;
  localparam logic [2:0] C_READ  = 3'd2;
  localparam logic [2:0] C_WRITE = 3'd3;
  localparam logic [2:0] C_CHAIN = 3'd4;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_REQ    = 4'd1;
  localparam logic [3:0] S_WAIT   = 4'd2;
  localparam logic [3:0] S_RSP    = 4'd3;
  localparam logic [3:0] S_CH_RD  = 4'd4;
  localparam logic [3:0] S_CH_RDW = 4'd5;
  localparam logic [3:0] S_CH_FR  = 4'd6;
  localparam logic [3:0] S_CH_FRW = 4'd7;
  localparam logic [3:0] S_HALT   = 4'd8;

  logic [3:0]         r_state;
  logic [2:0]         r_cmd;
  logic [DATA_SZ-1:0] r_cur;
  logic [DATA_SZ-1:0] r_next;
  logic [ADDR_SZ:0]   r_count;
  logic               r_fault;
  logic               r_cmd_ready;
  logic               r_rsp_valid;
  logic [DATA_SZ-1:0] r_rsp_data;
  logic               r_rsp_err;
  logic               r_halt;
  logic               r_alloc;
  logic               r_free;
  logic               r_wr;
  logic               r_rd;
  logic [DATA_SZ-1:0] r_data;
  logic [DATA_SZ-1:0] r_free_addr;
  logic [DATA_SZ-1:0] r_waddr;
  logic [DATA_SZ-1:0] r_wdata;
  logic [DATA_SZ-1:0] r_raddr;

  logic [ADDR_SZ:0]   w_count_inc;
  logic [DATA_SZ-1:0] w_fixnum;
  logic               w_start_link;
  logic               w_next_link;

  assign w_count_inc  = r_count + {{ADDR_SZ{1'b0}}, 1'b1};
  assign w_fixnum     = ZERO | DATA_SZ'(w_count_inc);
  assign w_start_link = |(i_cmd_addr & MUT_TAG);
  assign w_next_link  = |(r_next & MUT_TAG);

  // Command sequencing; strobes default low so each is high for exactly one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= 3'd0;
      r_cur       <= {DATA_SZ{1'b0}};
      r_next      <= {DATA_SZ{1'b0}};
      r_count     <= {(ADDR_SZ+1){1'b0}};
      r_fault     <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= {DATA_SZ{1'b0}};
      r_rsp_err   <= 1'b0;
      r_halt      <= 1'b0;
      r_alloc     <= 1'b0;
      r_free      <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_data      <= {DATA_SZ{1'b0}};
      r_free_addr <= {DATA_SZ{1'b0}};
      r_waddr     <= {DATA_SZ{1'b0}};
      r_wdata     <= {DATA_SZ{1'b0}};
      r_raddr     <= {DATA_SZ{1'b0}};
    end else begin
      r_alloc <= 1'b0;
      r_free  <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd       <= i_cmd;
            r_count     <= {(ADDR_SZ+1){1'b0}};
            r_fault     <= 1'b0;
            r_cmd_ready <= 1'b0;
            case (i_cmd)
              C_ALLOC: begin r_alloc <= 1'b1; r_data <= i_cmd_data; r_state <= S_REQ; end
              C_FREE:  begin r_free <= 1'b1; r_free_addr <= i_cmd_addr; r_state <= S_REQ; end
              C_READ:  begin r_rd <= 1'b1; r_raddr <= i_cmd_addr; r_state <= S_REQ; end
              C_WRITE: begin
                r_wr    <= 1'b1;
                r_waddr <= i_cmd_addr;
                r_wdata <= i_cmd_data;
                r_state <= S_REQ;
              end
              C_CHAIN: begin
                if (w_start_link) begin
                  r_rd    <= 1'b1;
                  r_raddr <= i_cmd_addr;
                  r_cur   <= i_cmd_addr;
                  r_state <= S_CH_RD;
                end else begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_data  <= ZERO;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RSP;
                end
              end
              default: begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= {DATA_SZ{1'b0}};
                r_rsp_err   <= 1'b1;
                r_state     <= S_RSP;
              end
            endcase
          end
        end
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          r_rsp_valid <= 1'b1;
          r_state     <= S_RSP;
          if (i_err) begin
            r_rsp_data <= {DATA_SZ{1'b0}};
            r_rsp_err  <= 1'b1;
            r_fault    <= 1'b1;
          end else begin
            r_rsp_err <= 1'b0;
            case (r_cmd)
              C_ALLOC: r_rsp_data <= i_alloc_addr;
              C_READ:  r_rsp_data <= i_rdata;
              default: r_rsp_data <= {DATA_SZ{1'b0}};
            endcase
          end
        end
        S_RSP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_fault) begin
              r_halt  <= 1'b1;
              r_state <= S_HALT;
            end else begin
              r_cmd_ready <= 1'b1;
              r_state     <= S_IDLE;
            end
          end
        end
        S_CH_RD: r_state <= S_CH_RDW;
        S_CH_RDW: begin
          if (i_err) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= {DATA_SZ{1'b0}};
            r_rsp_err   <= 1'b1;
            r_fault     <= 1'b1;
            r_state     <= S_RSP;
          end else begin
            r_next      <= i_rdata;
            r_free      <= 1'b1;
            r_free_addr <= r_cur;
            r_state     <= S_CH_FR;
          end
        end
        S_CH_FR: r_state <= S_CH_FRW;
        S_CH_FRW: begin
          r_count <= w_count_inc;
          // A link still tagged after MEM_MAX frees can only mean the chain loops.
          if (i_err || (w_next_link && (w_count_inc == CNT_MAX))) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= {DATA_SZ{1'b0}};
            r_rsp_err   <= 1'b1;
            r_fault     <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_next_link) begin
            r_cur   <= r_next;
            r_rd    <= 1'b1;
            r_raddr <= r_next;
            r_state <= S_CH_RD;
          end else begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_fixnum;
            r_rsp_err   <= 1'b0;
            r_state     <= S_RSP;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: begin
          r_halt      <= 1'b1;
          r_cmd_ready <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_HALT;
        end
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_halt      = r_halt;
  assign o_alloc     = r_alloc;
  assign o_free      = r_free;
  assign o_wr        = r_wr;
  assign o_rd        = r_rd;
  assign o_data      = r_data;
  assign o_free_addr = r_free_addr;
  assign o_waddr     = r_waddr;
  assign o_wdata     = r_wdata;
  assign o_raddr     = r_raddr;

endmodule

// File: tb/tb_alloc_ctl.sv
// Directed bench for alloc_ctl with a small memory-backed allocator stub and a strobe log.
module tb_alloc_ctl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic [2:0]  i_cmd;
  logic [15:0] i_cmd_addr;
  logic [15:0] i_cmd_data;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [15:0] o_rsp_data;
  logic        o_rsp_err;
  logic        o_halt;
  logic        o_alloc, o_free, o_wr, o_rd;
  logic [15:0] o_data, o_free_addr, o_waddr, o_wdata, o_raddr;
  logic [15:0] i_alloc_addr, i_rdata;
  logic        i_err;

  always #5 i_clk = ~i_clk;

  alloc_ctl dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd(i_cmd), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_halt(o_halt),
    .o_alloc(o_alloc), .o_free(o_free), .o_wr(o_wr), .o_rd(o_rd),
    .o_data(o_data), .o_free_addr(o_free_addr), .o_waddr(o_waddr),
    .o_wdata(o_wdata), .o_raddr(o_raddr),
    .i_alloc_addr(i_alloc_addr), .i_rdata(i_rdata), .i_err(i_err)
  );

  // Allocator stub: bump allocator from 16'h5000, 256-word memory, strobe log.
  logic [15:0] mem [0:255];
  logic [15:0] next_alloc = 16'h5000;
  int          n_overlap = 0;
  int          log_kind[$];
  logic [15:0] log_addr[$];

  always @(posedge i_clk) begin
    if ((32'(o_alloc) + 32'(o_free) + 32'(o_wr) + 32'(o_rd)) > 32'd1) n_overlap <= n_overlap + 1;
    if (o_alloc) begin
      i_alloc_addr <= next_alloc;
      mem[next_alloc[7:0]] <= o_data;
      next_alloc <= next_alloc + 16'd1;
      log_kind.push_back(0); log_addr.push_back(o_data);
    end
    if (o_free) begin log_kind.push_back(1); log_addr.push_back(o_free_addr); end
    if (o_wr) begin
      mem[o_waddr[7:0]] <= o_wdata;
      log_kind.push_back(3); log_addr.push_back(o_waddr);
    end
    if (o_rd) begin
      i_rdata <= mem[o_raddr[7:0]];
      log_kind.push_back(2); log_addr.push_back(o_raddr);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // All steps start and end 1 time unit after a rising edge.
  task automatic send(input logic [2:0] c, input logic [15:0] a, input logic [15:0] d);
    i_cmd_valid = 1'b1; i_cmd = c; i_cmd_addr = a; i_cmd_data = d;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!o_rsp_valid && lat < 2000) begin
      @(posedge i_clk); #1;
      lat++;
    end
  endtask

  task automatic accept();
    i_rsp_ready = 1'b1;
    @(posedge i_clk); #1;
    i_rsp_ready = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input logic [2:0] c, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int lat;
    check({tag, "_ready"}, 32'(o_cmd_ready), 32'd1);
    send(c, a, d);
    wait_rsp(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_data"}, 32'(o_rsp_data), 32'(exp_data));
    check({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
    accept();
  endtask

  task automatic pulse_reset();
    i_rst_n = 1'b0;
    #3;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  initial begin
    int lat;
    int base;
    i_rst_n = 1'b0; i_cmd_valid = 1'b0; i_cmd = 3'd0; i_cmd_addr = 16'h0000;
    i_cmd_data = 16'h0000; i_rsp_ready = 1'b0; i_err = 1'b0;
    #12;
    check("rst_strobes", {o_alloc, o_free, o_wr, o_rd}, 32'h0);
    check("rst_operands", {o_data, o_free_addr} | {o_waddr, o_wdata} | {16'h0, o_raddr}, 32'h0);
    check("rst_rsp", {o_rsp_valid, o_rsp_err, o_halt, o_rsp_data}, 32'h0);
    check("rst_ready", 32'(o_cmd_ready), 32'd1);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // ALLOC 16'h1234: single-cycle strobe, response two edges after accept.
    base = log_kind.size();
    send(3'd0, 16'h0000, 16'h1234);
    check("alloc_strobe", {o_alloc, o_free, o_wr, o_rd}, 32'h8);
    check("alloc_data", 32'(o_data), 32'h1234);
    @(posedge i_clk); #1;
    check("alloc_drop", 32'(o_alloc), 32'd0);
    wait_rsp(lat);
    check("alloc_lat", lat, 1);
    check("alloc_rsp", {o_rsp_err, o_rsp_data}, 32'h5000);
    accept();
    check("alloc_ready", 32'(o_cmd_ready), 32'd1);
    check("alloc_log", log_kind.size() - base, 1);

    base = log_kind.size();
    do_cmd("write", 3'd3, 16'h5000, 16'hBEEF, 16'h0000, 1'b0, 2);
    check("write_log", {16'(log_kind.size() - base), 16'(log_kind[base])}, {16'd1, 16'd3});
    check("write_addr", 32'(log_addr[base]), 32'h5000);
    do_cmd("read", 3'd2, 16'h5000, 16'h0000, 16'hBEEF, 1'b0, 2);
    check("read_log", {16'(log_kind.size() - base), 16'(log_kind[base+1])}, {16'd2, 16'd2});

    // Chain C -> B -> A, A's link untagged.
    do_cmd("alloc_a", 3'd0, 16'h0000, 16'h0001, 16'h5001, 1'b0, 2);
    do_cmd("alloc_b", 3'd0, 16'h0000, 16'h5001, 16'h5002, 1'b0, 2);
    do_cmd("alloc_c", 3'd0, 16'h0000, 16'h5002, 16'h5003, 1'b0, 2);
    base = log_kind.size();
    do_cmd("chain3", 3'd4, 16'h5003, 16'h0000, 16'h8003, 1'b0, 12);
    check("chain_nlog", log_kind.size() - base, 6);
    check("chain_s0", {16'(log_kind[base+0]), log_addr[base+0]}, {16'd2, 16'h5003});
    check("chain_s1", {16'(log_kind[base+1]), log_addr[base+1]}, {16'd1, 16'h5003});
    check("chain_s2", {16'(log_kind[base+2]), log_addr[base+2]}, {16'd2, 16'h5002});
    check("chain_s3", {16'(log_kind[base+3]), log_addr[base+3]}, {16'd1, 16'h5002});
    check("chain_s4", {16'(log_kind[base+4]), log_addr[base+4]}, {16'd2, 16'h5001});
    check("chain_s5", {16'(log_kind[base+5]), log_addr[base+5]}, {16'd1, 16'h5001});

    base = log_kind.size();
    do_cmd("chain_untag", 3'd4, 16'h0001, 16'h0000, 16'h8000, 1'b0, 0);
    do_cmd("invalid6", 3'd6, 16'h5000, 16'h0000, 16'h0000, 1'b1, 0);
    check("invalid_halt", {o_halt, o_cmd_ready}, 32'h1);
    check("nostrobe_log", log_kind.size() - base, 0);
    do_cmd("free", 3'd1, 16'h5000, 16'h0000, 16'h0000, 1'b0, 2);
    check("free_addr", {16'(log_kind[base]), log_addr[base]}, {16'd1, 16'h5000});

    // Allocator error during a READ: error response, then sticky halt.
    i_err = 1'b1;
    do_cmd("rd_err", 3'd2, 16'h5000, 16'h0000, 16'h0000, 1'b1, 2);
    i_err = 1'b0;
    check("halt_set", {o_halt, o_cmd_ready, o_rsp_valid}, 32'h4);
    base = log_kind.size();
    i_cmd_valid = 1'b1; i_cmd = 3'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clk); #1;
      check("halt_hold", {o_halt, o_cmd_ready, o_alloc, o_free, o_wr, o_rd}, 32'h20);
    end
    i_cmd_valid = 1'b0;
    check("halt_log", log_kind.size() - base, 0);
    pulse_reset();
    check("unhalt", {o_halt, o_cmd_ready, o_rsp_valid}, 32'h2);

    // Self-looping cell trips the cycle guard after MEM_MAX frees.
    do_cmd("loop_wr", 3'd3, 16'h5010, 16'h5010, 16'h0000, 1'b0, 2);
    do_cmd("loop_chain", 3'd4, 16'h5010, 16'h0000, 16'h0000, 1'b1, 1024);
    check("loop_halt", {o_halt, o_cmd_ready}, 32'h2);
    pulse_reset();

    // Reset in the middle of a chain walk.
    do_cmd("alloc_d", 3'd0, 16'h0000, 16'h0001, 16'h5004, 1'b0, 2);
    do_cmd("alloc_e", 3'd0, 16'h0000, 16'h5004, 16'h5005, 1'b0, 2);
    do_cmd("alloc_f", 3'd0, 16'h0000, 16'h5005, 16'h5006, 1'b0, 2);
    send(3'd4, 16'h5006, 16'h0000);
    repeat (3) begin @(posedge i_clk); #1; end
    i_rst_n = 1'b0;
    #1;
    check("frw_rst_strobes", {o_alloc, o_free, o_wr, o_rd, o_rsp_valid}, 32'h0);
    #2;
    i_rst_n = 1'b1;
    base = log_kind.size();
    @(posedge i_clk); #1;
    check("frw_rst_idle", {o_cmd_ready, o_rsp_valid, o_halt}, 32'h4);
    repeat (4) begin @(posedge i_clk); #1; end
    check("frw_rst_quiet", log_kind.size() - base, 0);

    send(3'd4, 16'h5006, 16'h0000);
    repeat (2) begin @(posedge i_clk); #1; end
    check("fr_pre", {o_free, o_free_addr}, {15'd0, 1'b1, 16'h5006});
    i_rst_n = 1'b0;
    #1;
    check("fr_async", {o_free, o_free_addr}, 32'h0);
    #2;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    check("fr_rst_idle", {o_cmd_ready, o_rsp_valid}, 32'h2);
    do_cmd("post_read", 3'd2, 16'h5000, 16'h0000, 16'hBEEF, 1'b0, 2);
    check("no_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
